// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared types, flag bit positions and format helpers for the
// pipelined floating-point multiplier. Format widths are supplied by the
// caller so one package serves every EXP_W/MAN_W instance.
package fp_mul_pkg;

    // Operand classification after subnormal flushing
    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    // Bit positions inside the 4-bit {NV, OF, UF, NX} flag word
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_NV = 3;
    localparam int FLAGS_W = 4;

    // Widest word the helpers can build; callers slice the low W bits
    localparam int MAX_W = 128;

    // Exponent bias 2^(exp_w-1)-1
    function automatic int fp_bias(input int exp_w);
        return (32'sd1 << (exp_w - 1)) - 32'sd1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only mantissa MSB set
    function automatic logic [MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] r;
        for (int i = 0; i < MAX_W; i++) begin
            r[i] = (i >= man_w) && (i < man_w + exp_w);
        end
        r[man_w-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/fp_mul_round.sv
// fp_mul_round: final-stage normalise, round, overflow/underflow and pack for
// the NORM x NORM path of fp_mul_pipe. Purely combinational.
// Build option: FP_MUL_RNE_EN selects round-to-nearest-even; when undefined
// the fraction is truncated (round toward zero). NX is reported either way.
module fp_mul_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [2*MAN_W+1:0]        prod_i,
    input  logic signed [EXP_W+1:0]   exp_i,
    input  logic                      sign_i,
    output logic [EXP_W+MAN_W:0]      data_o,
    output logic [FLAGS_W-1:0]        flags_o
);
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] EMAX   = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] E_NONE = {EW{1'b0}};

    logic                  msb_s;
    logic [MAN_W-1:0]      frac_s;
    logic                  guard_s;
    logic                  sticky_s;
    logic                  inc_s;
    logic [MAN_W:0]        frac_inc_s;
    logic signed [EW-1:0]  e_norm_s;
    logic signed [EW-1:0]  e_fin_s;
    logic                  nx_s;

    // Normalise the product, round it and range-check the final exponent
    always_comb begin
        data_o  = {(EXP_W+MAN_W+1){1'b0}};
        flags_o = {FLAGS_W{1'b0}};
        msb_s   = prod_i[PW-1];
        // Product in [2,4): drop one more bit so the hidden one sits at the top
        if (msb_s) begin
            frac_s   = prod_i[PW-2 -: MAN_W];
            guard_s  = prod_i[MAN_W];
            sticky_s = |prod_i[MAN_W-1:0];
        end else begin
            frac_s   = prod_i[PW-3 -: MAN_W];
            guard_s  = prod_i[MAN_W-1];
            sticky_s = |prod_i[MAN_W-2:0];
        end
        e_norm_s = exp_i + $signed({{(EW-1){1'b0}}, msb_s});
`ifdef FP_MUL_RNE_EN
        inc_s = guard_s & (sticky_s | frac_s[0]);
`else
        inc_s = 1'b0;
`endif
        frac_inc_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, inc_s};
        // A carry out of the fraction means the significand became 10.000:
        // the fraction bits are already zero, only the exponent moves
        e_fin_s = e_norm_s + $signed({{(EW-1){1'b0}}, frac_inc_s[MAN_W]});
        nx_s    = guard_s | sticky_s;
        if (e_fin_s >= EMAX) begin
            data_o            = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_o[FLAG_OF]  = 1'b1;
            flags_o[FLAG_NX]  = 1'b1;
        end else if (e_fin_s <= E_NONE) begin
            data_o            = {sign_i, {(EXP_W+MAN_W){1'b0}}};
            flags_o[FLAG_UF]  = 1'b1;
            flags_o[FLAG_NX]  = 1'b1;
        end else begin
            data_o            = {sign_i, e_fin_s[EXP_W-1:0], frac_inc_s[MAN_W-1:0]};
            flags_o[FLAG_NX]  = nx_s;
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage floating-point multiplier with valid/ready flow
// control. S1 classifies and sums exponents, S2 multiplies significands,
// S3 (fp_mul_round) normalises, rounds and packs. The whole pipe advances
// together whenever the output register can accept a new value.
// Build option: FP_MUL_RNE_EN (round-to-nearest-even, else truncate).
module fp_mul_pipe
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+MAN_W:0]      a,
    input  logic [EXP_W+MAN_W:0]      b,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [EXP_W+MAN_W:0]      out_data,
    output logic [FLAGS_W-1:0]        out_flags,
    output logic                      out_valid,
    input  logic                      out_ready
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic [MAX_W-1:0]     QNAN_WIDE = fp_canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN      = QNAN_WIDE[W-1:0];
    localparam logic signed [EW-1:0] BIAS_E    = EW'(fp_bias(EXP_W));

    // Subnormals classify as ZERO (flushed); sign is handled by the caller
    function automatic fp_class_e classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        fp_class_e        c;
        e = x[W-2 -: EXP_W];
        m = x[MAN_W-1:0];
        if (e == {EXP_W{1'b0}}) begin
            c = ZERO;
        end else if (e == {EXP_W{1'b1}}) begin
            c = (m == {MAN_W{1'b0}}) ? INF : NAN;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

    logic en_s;
    fp_class_e cls_a_s, cls_b_s;

    // Stage 1 next-state
    logic                  sign_d, spec_d;
    logic [W-1:0]          sdata_d;
    logic [FLAGS_W-1:0]    sflags_d;
    logic signed [EW-1:0]  esum_d;
    logic [MAN_W:0]        ma_d, mb_d;
    // Stage 1 registers
    logic                  v1_q, sign1_q, spec1_q;
    logic [W-1:0]          sdata1_q;
    logic [FLAGS_W-1:0]    sflags1_q;
    logic signed [EW-1:0]  e1_q;
    logic [MAN_W:0]        ma1_q, mb1_q;
    // Stage 2
    logic [PW-1:0]         prod_d;
    logic                  v2_q, sign2_q, spec2_q;
    logic [W-1:0]          sdata2_q;
    logic [FLAGS_W-1:0]    sflags2_q;
    logic signed [EW-1:0]  e2_q;
    logic [PW-1:0]         prod2_q;
    // Stage 3 / outputs
    logic [W-1:0]          rnd_data_s, out_data_d, out_data_q;
    logic [FLAGS_W-1:0]    rnd_flags_s, out_flags_d, out_flags_q;
    logic                  out_valid_q;

    assign en_s      = !out_valid_q || out_ready;
    assign in_ready  = en_s;
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;
    assign out_valid = out_valid_q;

    // S1: classify operands, resolve special results, sum biased exponents
    always_comb begin
        cls_a_s  = classify(a);
        cls_b_s  = classify(b);
        sign_d   = a[W-1] ^ b[W-1];
        spec_d   = 1'b1;
        sdata_d  = {W{1'b0}};
        sflags_d = {FLAGS_W{1'b0}};
        esum_d   = $signed({2'b00, a[W-2 -: EXP_W]}) + $signed({2'b00, b[W-2 -: EXP_W]}) - BIAS_E;
        ma_d     = {1'b1, a[MAN_W-1:0]};
        mb_d     = {1'b1, b[MAN_W-1:0]};
        if ((cls_a_s == NAN) || (cls_b_s == NAN) ||
            ((cls_a_s == INF) && (cls_b_s == ZERO)) ||
            ((cls_a_s == ZERO) && (cls_b_s == INF))) begin
            sdata_d           = QNAN;
            sflags_d[FLAG_NV] = 1'b1;
        end else if ((cls_a_s == INF) || (cls_b_s == INF)) begin
            sdata_d = {sign_d, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ((cls_a_s == ZERO) || (cls_b_s == ZERO)) begin
            sdata_d = {sign_d, {(W-1){1'b0}}};
        end else begin
            spec_d = 1'b0;
        end
    end

    // S2: full significand product
    always_comb begin
        prod_d = {{(MAN_W+1){1'b0}}, ma1_q} * {{(MAN_W+1){1'b0}}, mb1_q};
    end

    fp_mul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .prod_i  (prod2_q),
        .exp_i   (e2_q),
        .sign_i  (sign2_q),
        .data_o  (rnd_data_s),
        .flags_o (rnd_flags_s)
    );

    // S3: special results bypass the rounder
    always_comb begin
        out_data_d  = rnd_data_s;
        out_flags_d = rnd_flags_s;
        if (spec2_q) begin
            out_data_d  = sdata2_q;
            out_flags_d = sflags2_q;
        end else begin
            out_data_d  = rnd_data_s;
            out_flags_d = rnd_flags_s;
        end
    end

    // Pipeline registers: reset flushes everything, otherwise advance on en
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            spec1_q     <= 1'b0;
            sdata1_q    <= {W{1'b0}};
            sflags1_q   <= {FLAGS_W{1'b0}};
            e1_q        <= {EW{1'b0}};
            ma1_q       <= {(MAN_W+1){1'b0}};
            mb1_q       <= {(MAN_W+1){1'b0}};
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            spec2_q     <= 1'b0;
            sdata2_q    <= {W{1'b0}};
            sflags2_q   <= {FLAGS_W{1'b0}};
            e2_q        <= {EW{1'b0}};
            prod2_q     <= {PW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {W{1'b0}};
            out_flags_q <= {FLAGS_W{1'b0}};
        end else if (en_s) begin
            v1_q        <= in_valid;
            sign1_q     <= sign_d;
            spec1_q     <= spec_d;
            sdata1_q    <= sdata_d;
            sflags1_q   <= sflags_d;
            e1_q        <= esum_d;
            ma1_q       <= ma_d;
            mb1_q       <= mb_d;
            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            spec2_q     <= spec1_q;
            sdata2_q    <= sdata1_q;
            sflags2_q   <= sflags1_q;
            e2_q        <= e1_q;
            prod2_q     <= prod_d;
            out_valid_q <= v2_q;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (>=3).
REQ-002 SHALL have parameter MAN_W, default 23, stored-mantissa field width (>=2); word width W=1+EXP_W+MAN_W, BIAS=2^(EXP_W-1)-1.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports a, b  input  W  operands {sign, exp, man}.
REQ-006 SHALL have ports in_valid input 1 and in_ready output 1: operand handshake.
REQ-007 SHALL have port out_data  output  W  product.
REQ-008 SHALL have port out_flags  output  4  {NV, OF, UF, NX}: invalid, overflow, underflow, inexact.
REQ-009 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.

Function
REQ-010 SHALL be a 3-stage pipeline: S1 classify/sign/exponent sum; S2 (MAN_W+1)x(MAN_W+1) product; S3 normalise/round/pack.
REQ-011 SHALL accept an operand pair when in_valid && in_ready; its result SHALL present out_valid exactly 3 cycles later when unstalled.
REQ-012 SHALL advance all stages iff en = !out_valid || out_ready; in_ready SHALL equal en; bubbles are not collapsed.
REQ-013 SHALL hold out_data/out_flags stable while out_valid && !out_ready; results SHALL emerge in order, none lost or duplicated.
REQ-014 SHALL classify each operand: exp==0 -> ZERO (subnormals flushed, sign kept); exp all-ones, man==0 -> INF; exp all-ones, man!=0 -> NAN; else NORM.
REQ-015 SHALL set result sign = sign(a) XOR sign(b) for all non-NaN results.
REQ-016 SHALL output canonical qNaN (sign 0, exp all-ones, man MSB 1, rest 0) with NV=1 when either operand is NAN or for INF x ZERO.
REQ-017 SHALL output signed INF for INF x {NORM, INF}, signed zero for ZERO x {NORM, ZERO}, all flags 0.
REQ-018 SHALL compute the NORM x NORM exponent signed, width EXP_W+2: e = ea + eb - BIAS + n, n=1 when product MSB set (shift right one), else 0.
REQ-019 SHALL derive guard bit and sticky (OR of lower bits) below the kept MAN_W fraction bits; NX = guard|sticky.
REQ-020 SHALL, on rounding carry-out of the mantissa, renormalise to 1.0 and increment e.
REQ-021 SHALL output signed INF with OF=1, NX=1 when final e >= 2^EXP_W-1.
REQ-022 SHALL output signed zero with UF=1, NX=1 when final e <= 0 (no subnormal output).

Reset
REQ-023 SHALL on rst clear all stage valids, out_valid=0, out_data=0, out_flags=0; in_ready=1 the cycle after reset deasserts.
REQ-024 SHALL discard in-flight operations on rst asserted mid-stream; rst SHALL override en.

Configuration
REQ-025 SHALL, with FP_MUL_RNE_EN defined, round to nearest, ties to even (increment iff guard && (sticky || lsb)).
REQ-026 SHALL, without FP_MUL_RNE_EN, truncate (round toward zero); NX still reported; overflow still yields INF.

Structure
REQ-027 SHALL place in package fp_mul_pkg: operand-class enum {ZERO, NORM, INF, NAN}, flag bit-index constants, canonical-NaN and BIAS helper functions parameterised by EXP_W/MAN_W.
REQ-028 SHALL implement S3 normalise/round/overflow-underflow logic as sub-module fp_mul_round.

Verification (defaults EXP_W=8, MAN_W=23, FP_MUL_RNE_EN unless stated)
REQ-029 SHALL check 0x40000000 x 0x40400000 -> 0x40C00000, flags 0, out_valid 3 cycles after accept; 0x3FC00000 x 0x40000000 -> 0x40400000.
REQ-030 SHALL check 0x3FC00001 x 0x3FC00001 -> 0x40100002 NX=1 with FP_MUL_RNE_EN; -> 0x40100001 NX=1 without.
REQ-031 SHALL check 0x7F800000 x 0x00000000 -> 0x7FC00000 NV=1; 0xFF800000 x 0x40000000 -> 0xFF800000 flags 0; 0x80000000 x 0x40000000 -> 0x80000000.
REQ-032 SHALL check 0x7F000000 x 0x7F000000 -> 0x7F800000 OF=1 NX=1; 0x00800000 x 0x00800000 -> 0x00000000 UF=1 NX=1.
REQ-033 SHALL check 5 back-to-back pairs with out_ready low for 3 cycles once out_valid rises -> in_ready low exactly while out_valid && !out_ready, 5 results in order, held stable.
REQ-034 SHALL check rst asserted with 2 operations in flight -> out_valid=0, out_data=0 next cycle, no stale result emitted afterwards.
